// File: rtl/writeback_stage.sv
// Writeback stage: one held pipeline register, load alignment/extension,
// fault detection and a retired-instruction counter.
module writeback_stage #(
  parameter logic BIG_ENDIAN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_write_enable,
  input  logic [4:0]  in_write_address,
  input  logic [31:0] in_result,
  input  logic        in_memory_read,
  input  logic [2:0]  in_load_type,
  input  logic [31:0] in_memory_data,
  input  logic        stall,
  input  logic        flush,
  output logic        write_enable,
  output logic [4:0]  write_address,
  output logic [31:0] write_data,
  output logic        fault,
  output logic [31:0] retire_count
);

  typedef struct packed {
    logic        valid;
    logic        write_enable;
    logic [4:0]  write_address;
    logic [31:0] result;
    logic        memory_read;
    logic [2:0]  load_type;
    logic [31:0] memory_data;
  } wb_t;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LBU = 3'b001;
  localparam logic [2:0] LT_LH  = 3'b010;
  localparam logic [2:0] LT_LHU = 3'b011;
  localparam logic [2:0] LT_LW  = 3'b100;

  wb_t         held;
  wb_t         incoming;
  logic [1:0]  offset;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic        load_bad;
  logic        is_rsv;

  assign incoming = '{
    valid:         in_valid,
    write_enable:  in_write_enable,
    write_address: in_write_address,
    result:        in_result,
    memory_read:   in_memory_read,
    load_type:     in_load_type,
    memory_data:   in_memory_data
  };

  always_ff @(posedge clock) begin
    if (!reset) begin
      held         <= '0;
      retire_count <= '0;
    end else begin
      if (flush)       held <= '0;
      else if (!stall) held <= incoming;
      if (held.valid && !stall)
        retire_count <= retire_count + 32'd1;
    end
  end

  assign offset = held.result[1:0];
  assign is_rsv = held.load_type[2] & (|held.load_type[1:0]);

  always_comb begin
    byte_sel = '0;
    half_sel = '0;
    if (BIG_ENDIAN) begin
      unique case (offset)
        2'd0: byte_sel = held.memory_data[31:24];
        2'd1: byte_sel = held.memory_data[23:16];
        2'd2: byte_sel = held.memory_data[15:8];
        2'd3: byte_sel = held.memory_data[7:0];
      endcase
      half_sel = offset[1] ? held.memory_data[15:0]
                           : held.memory_data[31:16];
    end else begin
      unique case (offset)
        2'd0: byte_sel = held.memory_data[7:0];
        2'd1: byte_sel = held.memory_data[15:8];
        2'd2: byte_sel = held.memory_data[23:16];
        2'd3: byte_sel = held.memory_data[31:24];
      endcase
      half_sel = offset[1] ? held.memory_data[31:16]
                           : held.memory_data[15:0];
    end
  end

  always_comb begin
    load_data = '0;
    load_bad  = 1'b0;
    unique case (1'b1)
      (held.load_type == LT_LB):
        load_data = {{24{byte_sel[7]}}, byte_sel};
      (held.load_type == LT_LBU):
        load_data = {24'd0, byte_sel};
      (held.load_type == LT_LH): begin
        load_data = {{16{half_sel[15]}}, half_sel};
        load_bad  = offset[0];
      end
      (held.load_type == LT_LHU): begin
        load_data = {16'd0, half_sel};
        load_bad  = offset[0];
      end
      (held.load_type == LT_LW): begin
        load_data = held.memory_data;
        load_bad  = |offset;
      end
      is_rsv:
        load_bad = 1'b1;
    endcase
  end

  assign fault = held.valid & held.memory_read & load_bad;

  assign write_enable = held.valid & held.write_enable
                      & (|held.write_address)
                      & ~fault & ~stall;

  assign write_address = held.write_address;

  assign write_data = !write_enable   ? 32'd0
                    : held.memory_read ? load_data
                    :                    held.result;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: both byte orders, faults,
// stall/flush/reset interaction and the retire counter.
module tb_writeback_stage;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_write_enable;
  logic [4:0]  in_write_address;
  logic [31:0] in_result;
  logic        in_memory_read;
  logic [2:0]  in_load_type;
  logic [31:0] in_memory_data;
  logic        stall;
  logic        flush;
  logic        write_enable;
  logic [4:0]  write_address;
  logic [31:0] write_data;
  logic        fault;
  logic [31:0] retire_count;
  logic        le_write_enable;
  logic [4:0]  le_write_address;
  logic [31:0] le_write_data;
  logic        le_fault;
  logic [31:0] le_retire_count;

  int          total;
  int          bad;
  logic [31:0] exp_rc;

  writeback_stage #(.BIG_ENDIAN(1'b1)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid),
    .in_write_enable(in_write_enable),
    .in_write_address(in_write_address),
    .in_result(in_result),
    .in_memory_read(in_memory_read),
    .in_load_type(in_load_type),
    .in_memory_data(in_memory_data),
    .stall(stall), .flush(flush),
    .write_enable(write_enable),
    .write_address(write_address),
    .write_data(write_data),
    .fault(fault),
    .retire_count(retire_count)
  );

  writeback_stage #(.BIG_ENDIAN(1'b0)) dut_le (
    .clock(clock), .reset(reset),
    .in_valid(in_valid),
    .in_write_enable(in_write_enable),
    .in_write_address(in_write_address),
    .in_result(in_result),
    .in_memory_read(in_memory_read),
    .in_load_type(in_load_type),
    .in_memory_data(in_memory_data),
    .stall(stall), .flush(flush),
    .write_enable(le_write_enable),
    .write_address(le_write_address),
    .write_data(le_write_data),
    .fault(le_fault),
    .retire_count(le_retire_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic we,
                       input logic [4:0] a, input logic [31:0] r,
                       input logic mr, input logic [2:0] lt,
                       input logic [31:0] md);
    in_valid         = v;
    in_write_enable  = we;
    in_write_address = a;
    in_result        = r;
    in_memory_read   = mr;
    in_load_type     = lt;
    in_memory_data   = md;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    total++;
    if (write_enable !== 1'b0) begin
      bad++; $display("FAIL reset_we got=%b exp=0", write_enable);
    end
    total++;
    if (write_address !== 5'd0) begin
      bad++; $display("FAIL reset_addr got=%h exp=0", write_address);
    end
    total++;
    if (write_data !== 32'd0) begin
      bad++; $display("FAIL reset_data got=%h exp=0", write_data);
    end
    total++;
    if (fault !== 1'b0) begin
      bad++; $display("FAIL reset_fault got=%b exp=0", fault);
    end
    total++;
    if (retire_count !== 32'd0) begin
      bad++; $display("FAIL reset_rc got=%h exp=0", retire_count);
    end
    reset  = 1'b1;
    exp_rc = 32'd0;
  endtask

  task automatic test_alu();
    drive(1, 1, 5, 32'h12345678, 0, 0, 0);
    tick();
    total++;
    if (write_enable !== 1'b1) begin
      bad++; $display("FAIL alu_we got=%b exp=1", write_enable);
    end
    total++;
    if (write_address !== 5'd5) begin
      bad++; $display("FAIL alu_addr got=%h exp=05", write_address);
    end
    total++;
    if (write_data !== 32'h12345678) begin
      bad++; $display("FAIL alu_data got=%h exp=12345678", write_data);
    end
    total++;
    if (retire_count !== exp_rc) begin
      bad++; $display("FAIL alu_rc0 got=%h exp=%h", retire_count, exp_rc);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    exp_rc++;
    total++;
    if (retire_count !== exp_rc) begin
      bad++; $display("FAIL alu_rc1 got=%h exp=%h", retire_count, exp_rc);
    end
    total++;
    if (write_enable !== 1'b0) begin
      bad++; $display("FAIL alu_bubble_we got=%b exp=0", write_enable);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  lt [8];
    logic [31:0] rs [8];
    logic [31:0] md [8];
    logic [31:0] eb [8];
    logic [31:0] el [8];
    lt = '{3'b000, 3'b001, 3'b010, 3'b011,
           3'b010, 3'b000, 3'b100, 3'b000};
    rs = '{32'h1001, 32'h1001, 32'h1002, 32'h1000,
           32'h1000, 32'h1003, 32'h1004, 32'h1000};
    md = '{32'h11A23344, 32'h11A23344, 32'h11A23344, 32'h80001234,
           32'h80001234, 32'h11A23344, 32'hCAFEF00D, 32'h80FF0102};
    eb = '{32'hFFFFFFA2, 32'h000000A2, 32'h00003344, 32'h00008000,
           32'hFFFF8000, 32'h00000044, 32'hCAFEF00D, 32'hFFFFFF80};
    el = '{32'h00000033, 32'h00000033, 32'h000011A2, 32'h00001234,
           32'h00001234, 32'h00000011, 32'hCAFEF00D, 32'h00000002};
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 3, rs[i], 1, lt[i], md[i]);
      tick();
      total++;
      if (write_data !== eb[i]) begin
        bad++; $display("FAIL load_be[%0d] got=%h exp=%h",
                        i, write_data, eb[i]);
      end
      total++;
      if (le_write_data !== el[i]) begin
        bad++; $display("FAIL load_le[%0d] got=%h exp=%h",
                        i, le_write_data, el[i]);
      end
      total++;
      if (write_enable !== 1'b1) begin
        bad++; $display("FAIL load_we[%0d] got=%b exp=1",
                        i, write_enable);
      end
      total++;
      if (retire_count !== exp_rc) begin
        bad++; $display("FAIL load_rc[%0d] got=%h exp=%h",
                        i, retire_count, exp_rc);
      end
      exp_rc++;
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    total++;
    if (retire_count !== exp_rc) begin
      bad++; $display("FAIL load_rc_end got=%h exp=%h",
                      retire_count, exp_rc);
    end
  endtask

  task automatic test_fault();
    logic [2:0]  lt [6];
    logic [31:0] rs [6];
    logic        mr [6];
    logic        ef [6];
    lt = '{3'b010, 3'b100, 3'b101, 3'b011, 3'b100, 3'b000};
    rs = '{32'h1003, 32'h1002, 32'h1000, 32'h1001, 32'h1003, 32'h1003};
    mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    ef = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 4, rs[i], mr[i], lt[i], 32'h11A23344);
      tick();
      total++;
      if (fault !== ef[i]) begin
        bad++; $display("FAIL fault[%0d] got=%b exp=%b",
                        i, fault, ef[i]);
      end
      total++;
      if (write_enable !== !ef[i]) begin
        bad++; $display("FAIL fault_we[%0d] got=%b exp=%b",
                        i, write_enable, !ef[i]);
      end
      if (ef[i]) begin
        total++;
        if (write_data !== 32'd0) begin
          bad++; $display("FAIL fault_data[%0d] got=%h exp=0",
                          i, write_data);
        end
      end
      exp_rc++;
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    total++;
    if (retire_count !== exp_rc) begin
      bad++; $display("FAIL fault_rc got=%h exp=%h",
                      retire_count, exp_rc);
    end
  endtask

  task automatic test_stall();
    drive(1, 1, 7, 32'h00000077, 0, 0, 0);
    tick();
    stall = 1'b1;
    drive(1, 1, 9, 32'h00000099, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (write_enable !== 1'b0) begin
        bad++; $display("FAIL stall_we[%0d] got=%b exp=0",
                        i, write_enable);
      end
      total++;
      if (retire_count !== exp_rc) begin
        bad++; $display("FAIL stall_rc[%0d] got=%h exp=%h",
                        i, retire_count, exp_rc);
      end
      tick();
    end
    stall = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    total++;
    if (write_enable !== 1'b1 || write_address !== 5'd7) begin
      bad++; $display("FAIL stall_release got=%b/%h exp=1/07",
                      write_enable, write_address);
    end
    total++;
    if (write_data !== 32'h00000077) begin
      bad++; $display("FAIL stall_data got=%h exp=00000077", write_data);
    end
    tick();
    exp_rc++;
    total++;
    if (retire_count !== exp_rc || write_enable !== 1'b0) begin
      bad++; $display("FAIL stall_after got=%h/%b exp=%h/0",
                      retire_count, write_enable, exp_rc);
    end
  endtask

  task automatic test_flush();
    drive(1, 1, 9, 32'h00000099, 0, 0, 0);
    stall = 1'b1;
    flush = 1'b1;
    tick();
    stall = 1'b0;
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    total++;
    if (write_enable !== 1'b0 || write_address !== 5'd0) begin
      bad++; $display("FAIL flush_bubble got=%b/%h exp=0/00",
                      write_enable, write_address);
    end
    total++;
    if (write_data !== 32'd0 || fault !== 1'b0) begin
      bad++; $display("FAIL flush_data got=%h/%b exp=0/0",
                      write_data, fault);
    end
    tick();
    total++;
    if (retire_count !== exp_rc) begin
      bad++; $display("FAIL flush_rc got=%h exp=%h",
                      retire_count, exp_rc);
    end
  endtask

  task automatic test_zero_and_reset();
    drive(1, 1, 0, 32'hDEADBEEF, 0, 0, 0);
    tick();
    total++;
    if (write_enable !== 1'b0 || write_data !== 32'd0) begin
      bad++; $display("FAIL x0_write got=%b/%h exp=0/0",
                      write_enable, write_data);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    exp_rc++;
    total++;
    if (retire_count !== exp_rc) begin
      bad++; $display("FAIL x0_rc got=%h exp=%h", retire_count, exp_rc);
    end
    drive(1, 1, 12, 32'h12121212, 0, 0, 0);
    tick();
    stall = 1'b1;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    total++;
    if (write_enable !== 1'b0 || write_address !== 5'd0
        || write_data !== 32'd0 || fault !== 1'b0) begin
      bad++; $display("FAIL rst_stall_out got=%b/%h/%h/%b exp=0/0/0/0",
                      write_enable, write_address, write_data, fault);
    end
    total++;
    if (retire_count !== 32'd0) begin
      bad++; $display("FAIL rst_stall_rc got=%h exp=0", retire_count);
    end
    reset = 1'b1;
    stall = 1'b0;
    tick();
    total++;
    if (retire_count !== 32'd0 || write_enable !== 1'b0) begin
      bad++; $display("FAIL rst_after got=%h/%b exp=0/0",
                      retire_count, write_enable);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_alu();
    test_loads();
    test_fault();
    test_stall();
    test_flush();
    test_zero_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter: BIG_ENDIAN, default 1, byte-lane order for sub-word loads (1 = byte offset 0 at bits 31:24; 0 = byte offset 0 at bits 7:0).
REQ-002 Ports: reset reset, synchronous, active-low; clock clock.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  memory stage presents an instruction this cycle.
REQ-006 in_write_enable  input  1  instruction writes a GPR.
REQ-007 in_write_address  input  5  destination GPR.
REQ-008 in_result  input  32  ALU result, or effective address when in_memory_read=1.
REQ-009 in_memory_read  input  1  instruction is a load.
REQ-010 in_load_type  input  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101-111 reserved.
REQ-011 in_memory_data  input  32  raw aligned word from data memory.
REQ-012 stall  input  1  hold the stage contents.
REQ-013 flush  input  1  discard the incoming instruction and insert a bubble.
REQ-014 write_enable  output  1  register-file write strobe.
REQ-015 write_address  output  5  register-file write index.
REQ-016 write_data  output  32  register-file write value.
REQ-017 fault  output  1  held instruction has a misaligned or reserved load.
REQ-018 retire_count  output  32  count of instructions leaving the stage.

Function
REQ-019 Stage SHALL hold one pipeline register: valid, write_enable, write_address, result, memory_read, load_type, memory_data.
REQ-020 Each rising edge with reset=1, stall=0, flush=0: SHALL capture all in_* signals (latency 1 cycle).
REQ-021 flush=1 (regardless of stall): SHALL load a bubble (valid=0, write_enable=0, all other fields 0).
REQ-022 stall=1, flush=0: SHALL keep all held fields unchanged; retire_count SHALL NOT increment.
REQ-023 Outputs SHALL be combinational from the held register only, never from in_* directly.
REQ-024 write_enable output SHALL be 1 only when held valid=1, held write_enable=1, held write_address!=0, fault=0, stall=0.
REQ-025 write_address output SHALL equal held write_address; write_data SHALL be 0 whenever write_enable output is 0.
REQ-026 Non-load (memory_read=0): write_data SHALL equal held result.
REQ-027 Load: offset = result[1:0]; with BIG_ENDIAN=1, byte k SHALL be memory_data[31-8k -: 8] and halfword h (offset 0 or 2) SHALL be memory_data[31-8h -: 16]; with BIG_ENDIAN=0, byte k SHALL be memory_data[8k +: 8] and halfword h SHALL be memory_data[8h +: 16].
REQ-028 LB/LH SHALL sign-extend to 32 bits; LBU/LHU SHALL zero-extend; LW SHALL pass memory_data unchanged.
REQ-029 fault SHALL be 1 when held valid=1, memory_read=1 and any holds: LH/LHU with offset[0]=1; LW with offset!=0; load_type in 101-111.
REQ-030 fault SHALL NOT be raised for non-loads or bubbles.
REQ-031 retire_count SHALL increment by 1, wrapping 0xFFFFFFFF->0, on each edge where held valid=1 and stall=0 (faulted instructions included).
REQ-032 A write to address 0 SHALL be suppressed but SHALL still count as retired.

Reset
REQ-033 Rising edge with reset=0 SHALL clear the pipeline register to a bubble and retire_count to 0, overriding stall and flush.
REQ-034 After reset: write_enable=0, write_address=0, write_data=0, fault=0, retire_count=0.
REQ-035 Reset asserted mid-stall SHALL discard the held instruction; it SHALL NOT be written or counted.

Verification
REQ-036 ALU op: in_valid=1, write_enable=1, address=5, result=0x12345678 -> next cycle write_enable=1, address=5, write_data=0x12345678; retire_count=1 one cycle later.
REQ-037 LB, BIG_ENDIAN=1, result=0x1001, memory_data=0x11A23344 -> write_data=0xFFFFFFA2; same stimulus as LBU -> 0x000000A2.
REQ-038 LH at result=0x1003 -> fault=1, write_enable=0, retire_count still increments.
REQ-039 Stall held 3 cycles on valid instruction to address 7 -> write_enable=0 throughout, retire_count unchanged, then single write on release.
REQ-040 flush and stall both 1 with a valid input -> next cycle bubble; write_enable=0, no count.
REQ-041 Write to address 0 with data 0xDEADBEEF -> write_enable=0, write_data=0, retire_count+1; reset=0 for one edge -> all outputs 0.
